// File: rtl/wb_blk_crc_sink_pkg.sv
// Shared definitions for the block CRC sink: register map, bit positions,
// Wishbone cycle-type codes, FSM states and the CRC-32 polynomial.
package wb_blk_crc_pkg;

  // Register word indices, decoded from r_adr_i[4:2]
  localparam logic [2:0] REG_CTRL     = 3'd0;  // 0x00
  localparam logic [2:0] REG_STATUS   = 3'd1;  // 0x04
  localparam logic [2:0] REG_CRC_RES  = 3'd2;  // 0x08
  localparam logic [2:0] REG_BLK_CNT  = 3'd3;  // 0x0C
  localparam logic [2:0] REG_WORD_CNT = 3'd4;  // 0x10

  // CTRL bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_CLR    = 2;

  // STATUS bit positions
  localparam int ST_DONE    = 0;
  localparam int ST_OVR     = 1;
  localparam int ST_SEL_ERR = 2;

  // Wishbone cycle type identifiers
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  // IEEE 802.3 CRC-32, reflected form
  localparam logic [31:0] CRC32_POLY = 32'hEDB8_8320;

  typedef enum logic {
    OFF = 1'b0,
    ACC = 1'b1
  } state_e;

  // Layout matches the STATUS register, bit 0 = done
  typedef struct packed {
    logic sel_err;
    logic ovr;
    logic done;
  } status_t;

endpackage

// File: rtl/wb_blk_crc_sink_if.sv
// Bundles the two Wishbone slave ports of the sink: the DMA data port and
// the CPU register port. Signal names are seen from the slave side.
interface wb_blk_crc_sink_if;

  // DMA port
  logic [31:0] d_dat_i;
  logic [31:0] d_dat_o;
  logic [31:0] d_adr_i;
  logic [3:0]  d_sel_i;
  logic        d_we_i;
  logic        d_cyc_i;
  logic        d_stb_i;
  logic [2:0]  d_cti_i;
  logic [1:0]  d_bte_i;
  logic        d_ack_o;

  // Register port
  logic [31:0] r_dat_i;
  logic [31:0] r_dat_o;
  logic [7:0]  r_adr_i;
  logic [3:0]  r_sel_i;
  logic        r_we_i;
  logic        r_cyc_i;
  logic        r_stb_i;
  logic        r_ack_o;

  modport slave (
    input  d_dat_i, d_adr_i, d_sel_i, d_we_i, d_cyc_i, d_stb_i, d_cti_i, d_bte_i,
    output d_dat_o, d_ack_o,
    input  r_dat_i, r_adr_i, r_sel_i, r_we_i, r_cyc_i, r_stb_i,
    output r_dat_o, r_ack_o
  );

  modport master (
    output d_dat_i, d_adr_i, d_sel_i, d_we_i, d_cyc_i, d_stb_i, d_cti_i, d_bte_i,
    input  d_dat_o, d_ack_o,
    output r_dat_i, r_adr_i, r_sel_i, r_we_i, r_cyc_i, r_stb_i,
    input  r_dat_o, r_ack_o
  );

endinterface

// File: rtl/wb_blk_crc_sink_crc32_d32.sv
// Combinational CRC-32 update over one 32-bit word, consumed as four
// little-endian bytes, each byte LSB first (reflected CRC).
module crc32_d32
  import wb_blk_crc_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_v;

  // Unrolled bit-serial LFSR: data bit 0 (byte 0 LSB) enters first
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a value on
    // entry, so no path can leave it holding its old value (a latch).
    crc_v = crc_i;
    for (int i = 0; i < 32; i++) begin
      if (crc_v[0] ^ data_i[i]) crc_v = (crc_v >> 1) ^ CRC32_POLY;
      else                      crc_v = crc_v >> 1;
    end
    crc_o = crc_v;
  end

endmodule

// File: rtl/wb_blk_crc_sink.sv
// Wishbone block CRC sink. Words written on the DMA port feed a running
// CRC-32; at each block boundary the result is latched, DONE is raised and
// an interrupt may fire. Control/status live on a separate register port.
module wb_blk_crc_sink
  import wb_blk_crc_pkg::*;
#(
  parameter int unsigned BLK_WORDS  = 128,
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  wb_blk_crc_sink_if.slave bus,
  output logic             irq_o
);

  localparam logic [15:0] LAST_WORD = 16'(BLK_WORDS - 1);

  state_e      state_q, state_d;
  logic        d_ack_q, d_ack_d;
  logic        r_ack_q, r_ack_d;
  logic [31:0] r_dat_q, r_dat_d;
  logic        en_q, en_d;
  logic        irq_en_q, irq_en_d;
  status_t     status_q, status_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_res_q, crc_res_d;
  logic [31:0] blk_cnt_q, blk_cnt_d;
  logic [15:0] word_cnt_q, word_cnt_d;
  logic        irq_q, irq_d;

  logic [31:0] crc_next;
  logic [31:0] rd_mux;
  logic [2:0]  r_idx;
  logic [2:0]  w1c;
  logic        d_req, d_accept, full_word;
  logic        r_req, r_wr, ctrl_wr, stat_wr, clr;
  logic        crc_upd, sel_err_set, blk_end;
  logic        unused_inputs;

  // Bus decode
  assign d_req     = bus.d_cyc_i & bus.d_stb_i;
  assign d_accept  = d_ack_q & d_req & bus.d_we_i;
  assign full_word = (bus.d_sel_i == 4'hF);
  assign r_req     = bus.r_cyc_i & bus.r_stb_i;
  assign r_idx     = bus.r_adr_i[4:2];
  assign r_wr      = r_ack_q & r_req & bus.r_we_i;
  assign ctrl_wr   = r_wr & (r_idx == REG_CTRL);
  assign stat_wr   = r_wr & (r_idx == REG_STATUS);
  assign clr       = ctrl_wr & bus.r_dat_i[CTRL_CLR];
  assign w1c       = stat_wr ? bus.r_dat_i[2:0] : 3'b000;
  assign blk_end   = crc_upd & (word_cnt_q == LAST_WORD);

  // Address/burst-type inputs carry no information for this sink
  assign unused_inputs = ^{bus.d_adr_i, bus.d_bte_i, bus.r_sel_i,
                           bus.r_adr_i[7:5], bus.r_adr_i[1:0]};

  crc32_d32 u_crc (
    .crc_i  (crc_q),
    .data_i (bus.d_dat_i),
    .crc_o  (crc_next)
  );

  // DMA ack: classic gives one ack per two cycles; an incrementing burst
  // keeps ack high, and the end-of-burst beat gets its ack then ack drops
  always_comb begin
    d_ack_d = d_req & (~d_ack_q | (bus.d_cti_i == CTI_INCR));
  end

  // Register port ack and registered read data captured on the request cycle
  always_comb begin
    r_ack_d = r_req & ~r_ack_q;
    unique case (r_idx)
      REG_CTRL:     rd_mux = {30'b0, irq_en_q, en_q};
      REG_STATUS:   rd_mux = {29'b0, status_q};
      REG_CRC_RES:  rd_mux = crc_res_q;
      REG_BLK_CNT:  rd_mux = blk_cnt_q;
      REG_WORD_CNT: rd_mux = {16'b0, word_cnt_q};
      default:      rd_mux = 32'b0;
    endcase
    r_dat_d = r_ack_d ? rd_mux : 32'b0;
  end

  // FSM next state and per-word decisions; CLR discards a coincident word
  always_comb begin
    state_d     = state_q;
    crc_upd     = 1'b0;
    sel_err_set = 1'b0;
    unique case (state_q)
      OFF: begin
        if (en_q) state_d = ACC;
      end
      ACC: begin
        if (!en_q) state_d = OFF;
        if (d_accept && !clr) begin
          if (full_word) crc_upd     = 1'b1;
          else           sel_err_set = 1'b1;
        end
      end
      default: state_d = OFF;
    endcase
  end

  // Control, status, CRC and counter next-state
  always_comb begin
    en_d       = en_q;
    irq_en_d   = irq_en_q;
    crc_d      = crc_q;
    crc_res_d  = crc_res_q;
    blk_cnt_d  = blk_cnt_q;
    word_cnt_d = word_cnt_q;
    irq_d      = status_q.done & irq_en_q;

    if (ctrl_wr) begin
      en_d     = bus.r_dat_i[CTRL_EN];
      irq_en_d = bus.r_dat_i[CTRL_IRQ_EN];
    end

    // W1C first, then hardware sets so a coincident set wins
    status_d = status_t'(status_q & ~w1c);
    if (sel_err_set) status_d.sel_err = 1'b1;

    if (blk_end) begin
      status_d.done = 1'b1;
      if (status_q.done && !w1c[ST_DONE]) status_d.ovr = 1'b1;
      crc_res_d  = crc_next ^ CRC_XOROUT;
      blk_cnt_d  = blk_cnt_q + 32'd1;
      word_cnt_d = 16'd0;
      crc_d      = CRC_INIT;
    end else if (crc_upd) begin
      crc_d      = crc_next;
      word_cnt_d = word_cnt_q + 16'd1;
    end

    if (clr) begin
      status_d   = '0;
      crc_res_d  = 32'b0;
      blk_cnt_d  = 32'b0;
      word_cnt_d = 16'd0;
      crc_d      = CRC_INIT;
    end
  end

  // State register; reset also drops both acks immediately
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    // NOTE: clocked state uses non-blocking assignment so every register
    // samples pre-edge values, independent of statement order.
    if (wb_rst_i) begin
      state_q    <= OFF;
      d_ack_q    <= 1'b0;
      r_ack_q    <= 1'b0;
      r_dat_q    <= 32'b0;
      en_q       <= 1'b0;
      irq_en_q   <= 1'b0;
      status_q   <= '0;
      crc_q      <= CRC_INIT;
      crc_res_q  <= 32'b0;
      blk_cnt_q  <= 32'b0;
      word_cnt_q <= 16'd0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_ack_q    <= d_ack_d;
      r_ack_q    <= r_ack_d;
      r_dat_q    <= r_dat_d;
      en_q       <= en_d;
      irq_en_q   <= irq_en_d;
      status_q   <= status_d;
      crc_q      <= crc_d;
      crc_res_q  <= crc_res_d;
      blk_cnt_q  <= blk_cnt_d;
      word_cnt_q <= word_cnt_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.d_ack_o = d_ack_q;
  assign bus.d_dat_o = 32'b0;
  assign bus.r_ack_o = r_ack_q;
  assign bus.r_dat_o = r_dat_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_wb_blk_crc_sink.sv
// Bench for wb_blk_crc_sink. Two instances (BLK_WORDS=1 and 128) share one
// bus master; `sel` picks which instance's outputs are checked. Register
// reads push their expected value into a scoreboard; a monitor pops and
// compares whenever the selected instance acks a read.
module tb_wb_blk_crc_sink;
  import wb_blk_crc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wb_blk_crc_sink_if bus1 ();
  wb_blk_crc_sink_if bus128 ();
  logic irq1, irq128;

  wb_blk_crc_sink #(.BLK_WORDS(1)) dut1 (
    .wb_clk_i (clk), .wb_rst_i (rst), .bus (bus1), .irq_o (irq1)
  );
  wb_blk_crc_sink #(.BLK_WORDS(128)) dut128 (
    .wb_clk_i (clk), .wb_rst_i (rst), .bus (bus128), .irq_o (irq128)
  );

  // Shared master drive
  logic [31:0] m_d_dat = '0;
  logic [3:0]  m_d_sel = '0;
  logic        m_d_we = 0, m_d_cyc = 0, m_d_stb = 0;
  logic [2:0]  m_d_cti = CTI_CLASSIC;
  logic [31:0] m_r_dat = '0;
  logic [7:0]  m_r_adr = '0;
  logic        m_r_we = 0, m_r_cyc = 0, m_r_stb = 0;

  assign bus1.d_dat_i = m_d_dat;   assign bus128.d_dat_i = m_d_dat;
  assign bus1.d_adr_i = 32'h0;     assign bus128.d_adr_i = 32'h0;
  assign bus1.d_sel_i = m_d_sel;   assign bus128.d_sel_i = m_d_sel;
  assign bus1.d_we_i  = m_d_we;    assign bus128.d_we_i  = m_d_we;
  assign bus1.d_cyc_i = m_d_cyc;   assign bus128.d_cyc_i = m_d_cyc;
  assign bus1.d_stb_i = m_d_stb;   assign bus128.d_stb_i = m_d_stb;
  assign bus1.d_cti_i = m_d_cti;   assign bus128.d_cti_i = m_d_cti;
  assign bus1.d_bte_i = 2'b00;     assign bus128.d_bte_i = 2'b00;
  assign bus1.r_dat_i = m_r_dat;   assign bus128.r_dat_i = m_r_dat;
  assign bus1.r_adr_i = m_r_adr;   assign bus128.r_adr_i = m_r_adr;
  assign bus1.r_sel_i = 4'hF;      assign bus128.r_sel_i = 4'hF;
  assign bus1.r_we_i  = m_r_we;    assign bus128.r_we_i  = m_r_we;
  assign bus1.r_cyc_i = m_r_cyc;   assign bus128.r_cyc_i = m_r_cyc;
  assign bus1.r_stb_i = m_r_stb;   assign bus128.r_stb_i = m_r_stb;

  // Observed instance
  logic        sel = 1'b0;
  logic        s_r_ack, s_d_ack, s_irq;
  logic [31:0] s_r_dat;
  assign s_r_ack = sel ? bus128.r_ack_o : bus1.r_ack_o;
  assign s_d_ack = sel ? bus128.d_ack_o : bus1.d_ack_o;
  assign s_r_dat = sel ? bus128.r_dat_o : bus1.r_dat_o;
  assign s_irq   = sel ? irq128 : irq1;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: each read ack consumes one expectation
  always @(negedge clk) begin
    if (s_r_ack && !m_r_we) begin
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_underflow: unexpected read data %h (t=%0t)", s_r_dat, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check(e.name, s_r_dat, e.exp);
      end
    end
  end

  // Software CRC-32 of n words base, base+1, ... taken as little-endian bytes
  function automatic logic [31:0] blk_crc(input logic [31:0] base, input int n);
    logic [31:0] c, w;
    c = 32'hFFFF_FFFF;
    for (int k = 0; k < n; k++) begin
      w = base + 32'(k);
      for (int b = 0; b < 4; b++) begin
        c = c ^ {24'h0, w[8*b +: 8]};
        for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      end
    end
    return c ^ 32'hFFFF_FFFF;
  endfunction

  task automatic reg_xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat);
    int t;
    @(posedge clk); #1;
    m_r_cyc = 1; m_r_stb = 1; m_r_we = we; m_r_adr = adr; m_r_dat = dat;
    t = 0;
    @(negedge clk);
    while (!s_r_ack && t < 20) begin @(negedge clk); t++; end
    check("r_ack_seen", {31'b0, s_r_ack}, 32'd1);
    @(posedge clk); #1;
    m_r_cyc = 0; m_r_stb = 0; m_r_we = 0;
  endtask

  task automatic reg_write(input logic [7:0] adr, input logic [31:0] dat);
    reg_xfer(1'b1, adr, dat);
  endtask

  task automatic reg_read(input string name, input logic [7:0] adr, input logic [31:0] exp);
    sb.push_back('{name, exp});
    reg_xfer(1'b0, adr, 32'h0);
  endtask

  task automatic dma_write(input logic [31:0] dat, input logic [3:0] be);
    int t;
    @(posedge clk); #1;
    m_d_cyc = 1; m_d_stb = 1; m_d_we = 1; m_d_dat = dat; m_d_sel = be; m_d_cti = CTI_CLASSIC;
    t = 0;
    @(negedge clk);
    while (!s_d_ack && t < 20) begin @(negedge clk); t++; end
    check("d_ack_seen", {31'b0, s_d_ack}, 32'd1);
    @(posedge clk); #1;
    m_d_cyc = 0; m_d_stb = 0; m_d_we = 0;
  endtask

  // Incrementing burst of n full words base..base+n-1, last beat cti=111
  task automatic dma_burst(input int n, input logic [31:0] base);
    int acks, gaps, t;
    logic got;
    acks = 0; gaps = 0; t = 0;
    @(posedge clk); #1;
    m_d_cyc = 1; m_d_stb = 1; m_d_we = 1; m_d_sel = 4'hF; m_d_dat = base;
    m_d_cti = (n == 1) ? CTI_EOB : CTI_INCR;
    while (acks < n && t < n + 20) begin
      @(negedge clk); t++;
      got = s_d_ack;
      if (got) acks++;
      else if (acks > 0) gaps++;
      @(posedge clk); #1;
      if (got && acks < n) begin
        m_d_dat = base + 32'(acks);
        m_d_cti = (acks == n - 1) ? CTI_EOB : CTI_INCR;
      end
    end
    m_d_cyc = 0; m_d_stb = 0; m_d_we = 0; m_d_cti = CTI_CLASSIC;
    check("burst_acks", 32'(acks), 32'(n));
    check("burst_gaps", 32'(gaps), 32'd0);
    @(negedge clk);
    check("ack_drop_after_eob", {31'b0, s_d_ack}, 32'd0);
  endtask

  task automatic wait_irq(input string name, input logic exp);
    int t;
    t = 0;
    @(negedge clk);
    while (s_irq !== exp && t < 3) begin @(negedge clk); t++; end
    check(name, {31'b0, s_irq}, {31'b0, exp});
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic [31:0] crc_seq;
    crc_seq = blk_crc(32'h0, 128);

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    check("rst_d_ack", {31'b0, s_d_ack}, 32'd0);
    check("rst_irq", {31'b0, s_irq}, 32'd0);
    @(negedge clk) rst = 1'b0;
    reg_read("rst_ctrl",     8'h00, 32'h0);
    reg_read("rst_status",   8'h04, 32'h0);
    reg_read("rst_crc_res",  8'h08, 32'h0);
    reg_read("rst_blk_cnt",  8'h0C, 32'h0);
    reg_read("rst_word_cnt", 8'h10, 32'h0);
    reg_read("rst_unmapped", 8'h14, 32'h0);

    // BLK_WORDS=1: zero word
    reg_write(8'h00, 32'h3);
    @(posedge clk);
    dma_write(32'h0000_0000, 4'hF);
    wait_irq("irq_rise", 1'b1);
    reg_read("zero_crc_res",  8'h08, 32'h2144_DF1C);
    reg_read("zero_status",   8'h04, 32'h1);
    reg_read("zero_blk_cnt",  8'h0C, 32'h1);
    reg_read("zero_word_cnt", 8'h10, 32'h0);

    // BLK_WORDS=1: "1234", DONE still set so OVR follows
    dma_write(32'h3433_3231, 4'hF);
    reg_read("ascii_crc_res", 8'h08, 32'h9BE3_E0A3);
    reg_read("ascii_status",  8'h04, 32'h3);
    reg_read("ascii_blk_cnt", 8'h0C, 32'h2);
    reg_write(8'h04, 32'h1);
    wait_irq("irq_fall", 1'b0);
    reg_read("w1c_done_status", 8'h04, 32'h2);
    reg_write(8'h04, 32'h7);
    reg_read("w1c_all_status", 8'h04, 32'h0);

    // BLK_WORDS=128: full burst
    sel = 1'b1;
    reg_write(8'h00, 32'h7);
    reg_read("ctrl_clr_reads0", 8'h00, 32'h3);
    dma_burst(128, 32'h0);
    reg_read("b1_crc_res",  8'h08, crc_seq);
    reg_read("b1_status",   8'h04, 32'h1);
    reg_read("b1_blk_cnt",  8'h0C, 32'h1);
    reg_read("b1_word_cnt", 8'h10, 32'h0);

    // Second block without clearing DONE
    dma_burst(128, 32'h1000);
    reg_read("b2_crc_res", 8'h08, blk_crc(32'h1000, 128));
    reg_read("b2_status",  8'h04, 32'h3);
    reg_read("b2_blk_cnt", 8'h0C, 32'h2);

    // Partial-select word mid-block is dropped
    reg_write(8'h00, 32'h7);
    reg_read("clr_status", 8'h04, 32'h0);
    dma_burst(64, 32'h0);
    dma_write(32'hDEAD_BEEF, 4'h3);
    reg_read("sel_word_cnt", 8'h10, 32'd64);
    reg_read("sel_status",   8'h04, 32'h4);
    dma_burst(64, 32'd64);
    reg_read("sel_crc_res", 8'h08, crc_seq);
    reg_read("sel_status2", 8'h04, 32'h5);
    reg_read("sel_blk_cnt", 8'h0C, 32'h1);

    // CLR coinciding with a DMA accept at WORD_CNT=5
    reg_write(8'h00, 32'h7);
    for (int i = 0; i < 5; i++) dma_write(32'(i), 4'hF);
    reg_read("pre_clr_word_cnt", 8'h10, 32'd5);
    fork
      reg_write(8'h00, 32'h7);
      dma_write(32'h0000_0055, 4'hF);
    join
    reg_read("clr_word_cnt", 8'h10, 32'h0);
    reg_read("clr_blk_cnt",  8'h0C, 32'h0);
    dma_burst(128, 32'h0);
    reg_read("post_clr_crc_res", 8'h08, crc_seq);
    reg_read("post_clr_blk_cnt", 8'h0C, 32'h1);

    // Asynchronous reset in the middle of a burst
    @(posedge clk); #1;
    m_d_cyc = 1; m_d_stb = 1; m_d_we = 1; m_d_sel = 4'hF; m_d_cti = CTI_INCR; m_d_dat = 32'h77;
    t = 0;
    @(negedge clk);
    while (!s_d_ack && t < 20) begin @(negedge clk); t++; end
    check("mid_burst_ack", {31'b0, s_d_ack}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_ack_drop", {31'b0, s_d_ack}, 32'd0);
    check("async_irq_drop", {31'b0, s_irq}, 32'd0);
    m_d_cyc = 0; m_d_stb = 0; m_d_we = 0; m_d_cti = CTI_CLASSIC;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    reg_read("ar_ctrl",     8'h00, 32'h0);
    reg_read("ar_status",   8'h04, 32'h0);
    reg_read("ar_crc_res",  8'h08, 32'h0);
    reg_read("ar_blk_cnt",  8'h0C, 32'h0);
    reg_read("ar_word_cnt", 8'h10, 32'h0);

    repeat (3) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_blk_crc_sink.md
Name: wb_blk_crc_sink

Overview:
- Wishbone slave on the SD controller DMA bus. It sits on a `dma_mux` slave slot downstream of the SDC DMA master and consumes the block data the controller writes after a card read.
- Every accepted full-word write feeds a running CRC-32. Word and block counters run alongside the CRC.
- At each block boundary it latches the CRC, raises a done flag and can raise an IRQ.
- A second Wishbone slave port on the CPU-side `wb_mux` exposes control and status registers. Software uses it to check read-back data integrity without RAM readout.

Parameters:
- BLK_WORDS, 128, 32-bit words per block (512 bytes); legal range 1..65535.
- CRC_INIT, 32'hFFFF_FFFF, CRC register value at block start.
- CRC_XOROUT, 32'hFFFF_FFFF, value XORed into the result on latch.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  reset, asynchronous, active-high.
- d_dat_i  in  32  DMA write data.
- d_dat_o  out  32  DMA read data, always 0.
- d_adr_i  in  32  DMA address, ignored.
- d_sel_i  in  4  byte selects.
- d_we_i  in  1  write enable.
- d_cyc_i  in  1  cycle.
- d_stb_i  in  1  strobe.
- d_cti_i  in  3  cycle type.
- d_bte_i  in  2  burst type, ignored.
- d_ack_o  out  1  acknowledge.
- r_dat_i  in  32  register write data.
- r_dat_o  out  32  register read data.
- r_adr_i  in  8  byte address; bits [4:2] decoded.
- r_sel_i  in  4  ignored; full-word access only.
- r_we_i  in  1  write enable.
- r_cyc_i  in  1  cycle.
- r_stb_i  in  1  strobe.
- r_ack_o  out  1  acknowledge.
- irq_o  out  1  level interrupt.

Behaviour:
- Reset: all outputs 0; CTRL=0; STATUS=0; CRC_RES=0; BLK_CNT=0; WORD_CNT=0; crc_q=CRC_INIT; state=OFF.
- Register map:
  - 0x00 CTRL RW: bit0 EN, bit1 IRQ_EN, bit2 CLR (self-clearing, reads 0).
  - 0x04 STATUS RW1C: bit0 DONE, bit1 OVR, bit2 SEL_ERR.
  - 0x08 CRC_RES RO.
  - 0x0C BLK_CNT RO, 32-bit, wraps to 0.
  - 0x10 WORD_CNT RO, words in current block.
  - Others read 0; writes to them are ignored.
- Register port timing: r_ack_o asserts one cycle after r_cyc_i & r_stb_i & !r_ack_o and lasts one cycle. Read data is registered and valid with the ack. The write takes effect on the ack cycle.
- DMA port, classic cycle (cti 000 or 111): d_ack_o = registered (d_cyc_i & d_stb_i & !d_ack_o). This gives one ack per two cycles.
- DMA port, incrementing burst (cti 010): after the first wait cycle, d_ack_o stays high every cycle while cyc & stb. The cycle with cti 111 receives its ack and then ack drops.
- A word is accepted on d_ack_o & d_we_i, using the data and sel sampled on the strobe cycle.
- Reads on the DMA port are acked with data 0 and have no side effect.
- FSM:
  - OFF: writes are acked and discarded; crc_q and WORD_CNT hold. EN=1 → ACC.
  - ACC: each accepted word with sel=4'hF updates crc_q and increments WORD_CNT.
  - ACC, accepted word with sel≠4'hF: sets SEL_ERR; the word is not counted and crc_q does not change.
  - ACC, EN=0: go to OFF; the partial block is kept and resumes on re-enable.
- CRC: IEEE 802.3 reflected polynomial 0xEDB88320. Each word is processed as 4 bytes in little-endian order (d_dat_i[7:0] first), 32 bits per cycle.
- Block end: the accepted word with WORD_CNT==BLK_WORDS-1 does all of the following in the same cycle:
  - CRC_RES <= next_crc ^ CRC_XOROUT.
  - DONE <= 1.
  - BLK_CNT += 1.
  - WORD_CNT <= 0.
  - crc_q <= CRC_INIT.
- Overrun: OVR is set if DONE is already 1 at block end and is not being W1C-cleared in that same cycle. CRC_RES is overwritten regardless.
- Simultaneous W1C of DONE and a block end: the set wins.
- CLR write: WORD_CNT, BLK_CNT, STATUS and CRC_RES are zeroed and crc_q returns to CRC_INIT. A DMA word accepted in the same cycle is discarded; CLR wins.
- irq_o = DONE & IRQ_EN, registered (one cycle after DONE rises).
- Reset mid-burst: all state clears immediately and d_ack_o drops asynchronously. The master must restart its cycle.
- BLK_WORDS=1: every accepted full word is a block end.

Decomposition:
- Package `wb_blk_crc_pkg`: register offsets, CTRL/STATUS bit indices, CTI codes (CTI_CLASSIC, CTI_INCR, CTI_EOB), state enum {OFF, ACC}, CRC32_POLY.
- Sub-module `crc32_d32`: combinational, (crc_in[31:0], data[31:0]) → crc_out[31:0] for four reflected bytes. Unit-testable on its own.

Test Plan:
- BLK_WORDS=1, EN=1, IRQ_EN=1; DMA write 32'h0000_0000 → CRC_RES=32'h2144DF1C, DONE=1, BLK_CNT=1, irq_o=1 within 2 cycles.
- BLK_WORDS=1; write 32'h3433_3231 (ASCII "1234") → CRC_RES=32'h9BE3E0A3. Then W1C STATUS=1 → irq_o=0.
- BLK_WORDS=128; 128-word burst (cti 010, last 111) of incrementing data 0..127 → 128 acks with no gaps after the first. CRC_RES matches the software model, WORD_CNT=0, BLK_CNT=1.
- Two blocks back-to-back without clearing DONE → OVR=1, CRC_RES equals the second block's CRC, BLK_CNT=2.
- Write with sel=4'h3 mid-block → SEL_ERR=1, WORD_CNT unchanged, final CRC equals that of the block without the word.
- CLR issued in the same cycle as a DMA accept at WORD_CNT=5 → WORD_CNT=0, crc_q=CRC_INIT. Async reset mid-burst → d_ack_o=0 in the same cycle, all registers read 0.
